nn_layer_sequencer: RTL and testbench
=====================================

# nn_layer_sequencer

Control stage placed directly upstream of a fully-connected layer instance in the inference chain. It captures an input activation vector and streams it one element per cycle into the layer's shared `data_in`/`input_valid` inputs. It drives the layer's `local_addr` weight-memory address one cycle ahead of each element to match the registered weight read. It then waits for every neuron's `out_valid`, latches the packed layer output, and pulses `done`, so sequencers can be chained layer to layer.

## Interface

Parameters:
- `NUM_INPUTS`, 784: elements per input vector, equal to the downstream layer's fan-in.
- `NUM_NEURONS`, 128: neurons in the downstream layer.
- `DATA_WIDTH`, 16: element width, Q-format unchanged by this block.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `start`  in  1  request to run one vector; sampled only in IDLE.
- `vec_in`  in  NUM_INPUTS*DATA_WIDTH  input vector, element k at `[k*DATA_WIDTH +: DATA_WIDTH]`; sampled on accepted `start`.
- `local_addr`  out  32  weight address to the layer.
- `data_out`  out  DATA_WIDTH  element to the layer's `data_in`.
- `data_valid`  out  1  to the layer's `input_valid`.
- `out_valids`  in  NUM_NEURONS  per-neuron valid from the layer.
- `layer_out`  in  NUM_NEURONS*DATA_WIDTH  packed layer result.
- `result`  out  NUM_NEURONS*DATA_WIDTH  latched layer result.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when `result` is updated.

## Operation

- States:
  - IDLE
  - STREAM: issues addresses 0..NUM_INPUTS-1.
  - FLUSH: one cycle, drains the last element.
  - WAIT: waits for all neuron valids.
  - DONE: one cycle.
- IDLE → STREAM on `start`=1. Same edge: `vec_in` copied into an internal vector register, address counter cleared to 0.
- STREAM, each cycle:
  - `local_addr` = counter; counter increments.
  - The element for the previous cycle's address is presented: `data_out` = vec[counter-1], `data_valid` = 1 (valid from the second STREAM cycle).
- STREAM → FLUSH on the cycle `local_addr` = NUM_INPUTS-1.
- FLUSH: `data_out` = vec[NUM_INPUTS-1], `data_valid` = 1, `local_addr` holds NUM_INPUTS-1.
- FLUSH → WAIT unconditionally.
- WAIT → DONE when `&out_valids` = 1. On that edge `result` <= `layer_out`.
- DONE: `done` = 1. DONE → IDLE unconditionally.
- `start` while `busy` is ignored; no queuing.
- `vec_in` changes after acceptance have no effect on the current run.
- `out_valids` bits are ignored outside WAIT.
- No timeout in WAIT; the block stays there until all valids are high or reset.
- Elements are forwarded bit-exact; no arithmetic on data. The counter is at least clog2(NUM_INPUTS+1) bits, zero-extended to 32.

## Timing

- Reset (`rst`=0 at a rising edge), outputs:
  - `local_addr`=0, `data_out`=0, `data_valid`=0
  - `busy`=0, `done`=0, `result`=0
  - state IDLE, vector register 0
- Reset asserted mid-run aborts immediately. Next cycle is IDLE with the reset values above. `result` is cleared, not preserved.
- Address-to-data skew is exactly 1 cycle: element k is valid on the cycle after `local_addr`=k. This matches the registered weight memory read.
- `data_valid` is high for exactly NUM_INPUTS consecutive cycles per run, with no gaps.
- Latency from `start` accepted (edge T):
  - first `data_valid` at cycle T+2
  - last `data_valid` at cycle T+NUM_INPUTS+1
- `done` rises the cycle after the edge that samples `&out_valids`=1. `result` is valid on that same cycle and held until the next `done` or reset.
- `busy` rises the cycle after `start` is accepted and falls the cycle after `done`.
- A new `start` is accepted on the first IDLE cycle after DONE.
- NUM_INPUTS=1: STREAM lasts one cycle, then FLUSH; single `data_valid` pulse.

## Test plan

- Reset: hold `rst`=0 for 3 cycles with `start`=1 → all outputs 0, `busy`=0, no `data_valid`.
- Streaming order, NUM_INPUTS=4, vec={0x0004,0x0003,0x0002,0x0001} (element 0 = 0x0001):
  - `local_addr` 0,1,2,3 on cycles T+1..T+4
  - `data_out` 0x0001..0x0004 with `data_valid`=1 on cycles T+2..T+5, exactly 4 pulses
- Completion, NUM_NEURONS=2: raise `out_valids`=2'b01, then 2'b11 five cycles later with `layer_out`=0xBEEF_1234 → `done` pulses once, the cycle after 2'b11 is sampled; `result`=0xBEEF_1234; 2'b01 alone never triggers `done`.
- Busy rejection: pulse `start` with a different `vec_in` during STREAM and WAIT → stream contents unchanged, no second run, one `done`.
- Mid-run reset: assert `rst`=0 when `local_addr`=2 → next cycle `data_valid`=0, `busy`=0, `result`=0. A fresh `start` afterwards restarts at address 0.
- Back-to-back: `start` held high continuously → a second run begins the first IDLE cycle after `done`; `data_valid` pulse count is 2×NUM_INPUTS.

Source files
------------

// File: rtl/nn_layer_sequencer.sv
// Sequencer in front of a fully-connected layer: captures an activation vector,
// streams it one element per cycle behind a one-cycle-early weight address, then latches the layer result.
module nn_layer_sequencer #(
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 128,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]  vec_in,
  output logic [31:0]                       local_addr,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic                              data_valid,
  input  logic [NUM_NEURONS-1:0]            out_valids,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] layer_out,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] result,
  output logic                              busy,
  output logic                              done,
  output logic [2:0]                        fsm_state
);

  localparam int CW = $clog2(NUM_INPUTS + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_INPUTS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STREAM = 3'd1,
    FLUSH  = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                          state;
  logic [CW-1:0]                   cnt;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] vec;

  assign local_addr = 32'(cnt);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign fsm_state  = state;

  // Handshake: start is a level sampled only in IDLE; data_valid qualifies data_out
  // with no backpressure; done is a single-cycle strobe that result has been updated.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      vec        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      result     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec   <= vec_in;
            cnt   <= '0;
            state <= STREAM;
          end
        end
        STREAM: begin
          // Element for the address shown this cycle appears next cycle,
          // lining up with the layer's registered weight read.
          data_out   <= vec[local_addr*DATA_WIDTH +: DATA_WIDTH];
          data_valid <= 1'b1;
          if (cnt == LAST) begin
            state <= FLUSH;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FLUSH: begin
          data_valid <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          if (&out_valids) begin
            result <= layer_out;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer (4 inputs, 2 neurons): streamed elements, address skew
// and latched results are checked against queues filled when stimulus is driven.
module tb_nn_layer_sequencer;

  localparam int NI = 4;
  localparam int NN = 2;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NI*DW-1:0]  vec_in;
  logic [31:0]       local_addr;
  logic [DW-1:0]     data_out;
  logic              data_valid;
  logic [NN-1:0]     out_valids;
  logic [NN*DW-1:0]  layer_out;
  logic [NN*DW-1:0]  result;
  logic              busy;
  logic              done;
  logic [2:0]        fsm_state;

  nn_layer_sequencer #(
    .NUM_INPUTS (NI),
    .NUM_NEURONS(NN),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .vec_in    (vec_in),
    .local_addr(local_addr),
    .data_out  (data_out),
    .data_valid(data_valid),
    .out_valids(out_valids),
    .layer_out (layer_out),
    .result    (result),
    .busy      (busy),
    .done      (done),
    .fsm_state (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [DW-1:0]    exp_q[$];
  logic [31:0]      addr_q[$];
  logic [NN*DW-1:0] res_q[$];
  int total = 0;
  int bad = 0;
  int vcount = 0;
  int dcount = 0;
  logic [31:0] prev_addr = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic push_vec(input logic [NI*DW-1:0] v);
    for (int k = 0; k < NI; k++) begin
      exp_q.push_back(v[k*DW +: DW]);
      addr_q.push_back(32'(k));
    end
  endtask

  // Call just after a negedge with the DUT idle; returns #1 after the accepting edge.
  task automatic start_run(input logic [NI*DW-1:0] v);
    start  = 1'b1;
    vec_in = v;
    push_vec(v);
    @(posedge clk);
    #1;
    start  = 1'b0;
    vec_in = ~v;
  endtask

  task automatic wait_done(input int budget, input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(tag, 64'(ok), 64'd1);
  endtask

  // monitor: data and the address one cycle earlier, plus result on done
  always @(negedge clk) begin
    if (data_valid) begin
      vcount++;
      if (exp_q.size() == 0) check_eq("dv_extra", 64'(data_valid), 64'd0);
      else check_eq("data", 64'(data_out), 64'(exp_q.pop_front()));
      if (addr_q.size() != 0) check_eq("addr_skew", 64'(prev_addr), 64'(addr_q.pop_front()));
    end
    if (done) begin
      dcount++;
      if (res_q.size() == 0) check_eq("done_extra", 64'(done), 64'd0);
      else check_eq("result", 64'(result), 64'(res_q.pop_front()));
    end
    prev_addr = local_addr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NI*DW-1:0] v1, v2;
    logic [NN*DW-1:0] lv;
    logic found;
    int base_v, base_d, gap;

    rst        = 1'b0;
    start      = 1'b1;
    vec_in     = {$urandom, $urandom};
    out_valids = '0;
    layer_out  = '0;

    // reset held 3 cycles with start high
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_dv", 64'(data_valid), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_addr", 64'(local_addr), 64'd0);
      check_eq("rst_data", 64'(data_out), 64'd0);
      check_eq("rst_result", 64'(result), 64'd0);
    end
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);

    // ordered stream, busy rejection in STREAM and WAIT, partial valids
    start_run(64'h0004_0003_0002_0001);
    @(negedge clk);
    check_eq("lat_addr0", 64'(local_addr), 64'd0);
    check_eq("lat_dv0", 64'(data_valid), 64'd0);
    check_eq("busy_rise", 64'(busy), 64'd1);
    start  = 1'b1;
    vec_in = 64'hAAAA_BBBB_CCCC_DDDD;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    vec_in = 64'h1111_2222_3333_4444;
    @(posedge clk);
    #1 start = 1'b0;
    out_valids = 2'b01;
    repeat (5) begin
      @(negedge clk);
      check_eq("no_done_partial", 64'(done), 64'd0);
    end
    layer_out  = 32'hBEEF_1234;
    out_valids = 2'b11;
    res_q.push_back(32'hBEEF_1234);
    @(negedge clk);
    check_eq("done_pulse", 64'(done), 64'd1);
    check_eq("done_busy", 64'(busy), 64'd1);
    out_valids = '0;
    @(negedge clk);
    check_eq("done_single", 64'(done), 64'd0);
    check_eq("busy_fall", 64'(busy), 64'd0);
    check_eq("hold_result", 64'(result), 64'hBEEF_1234);
    repeat (4) @(negedge clk);
    check_eq("run1_pulses", 64'(vcount), 64'd4);
    check_eq("run1_dones", 64'(dcount), 64'd1);
    check_eq("run1_idle", 64'(busy), 64'd0);

    // mid-run reset at address 2
    start_run({$urandom, $urandom});
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (local_addr == 32'd2) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("reach_addr2", 64'(found), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_dv", 64'(data_valid), 64'd0);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_result", 64'(result), 64'd0);
    check_eq("abort_addr", 64'(local_addr), 64'd0);
    exp_q.delete();
    addr_q.delete();
    rst = 1'b1;
    @(negedge clk);

    // fresh run after abort restarts at address 0
    base_v = vcount;
    lv = $urandom;
    layer_out = lv;
    res_q.push_back(lv);
    start_run({$urandom, $urandom});
    out_valids = 2'b11;
    wait_done(20, "fresh_done_timeout");
    out_valids = '0;
    @(negedge clk);
    check_eq("fresh_pulses", 64'(vcount - base_v), 64'd4);

    // back-to-back with start held high
    base_v = vcount;
    base_d = dcount;
    v1 = {$urandom, $urandom};
    v2 = {$urandom, $urandom};
    lv = $urandom;
    layer_out  = lv;
    out_valids = 2'b11;
    res_q.push_back(lv);
    res_q.push_back(lv);
    push_vec(v1);
    push_vec(v2);
    start  = 1'b1;
    vec_in = v1;
    @(posedge clk);
    #1 vec_in = v2;
    wait_done(30, "b2b_done1_timeout");
    gap = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (data_valid) begin
        gap = k;
        break;
      end
    end
    check_eq("b2b_restart_gap", 64'(gap), 64'd3);
    wait_done(30, "b2b_done2_timeout");
    start      = 1'b0;
    out_valids = '0;
    repeat (8) @(negedge clk);
    check_eq("b2b_pulses", 64'(vcount - base_v), 64'(2 * NI));
    check_eq("b2b_dones", 64'(dcount - base_d), 64'd2);
    check_eq("b2b_idle", 64'(busy), 64'd0);

    check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check_eq("res_q_empty", 64'(res_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
